// File: rtl/mdu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring) unit
// holding architectural HI/LO, one bit per cycle over a shared datapath.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_flush,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    mdu_state_e         r_state;
    mdu_state_e         w_state_next;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz_op;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_busy;
    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic               w_wr_ok;

    logic               w_op_signed;
    logic               w_op_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH:0]     w_add_x;
    logic [WIDTH:0]     w_add_y;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_step;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (i_start && !i_flush) w_state_next = RUN;
            RUN: begin
                if (i_flush) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_next = FIX;
                end
            end
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        w_busy   = (r_state != IDLE);
        w_load   = (r_state == IDLE) && i_start && !i_flush;
        w_step   = (r_state == RUN) && !i_flush;
        w_finish = (r_state == FIX) && !i_flush;
        w_wr_ok  = (r_state == IDLE);
    end

    always_comb begin
        w_op_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
        w_op_div    = (i_op == MDU_DIV) || (i_op == MDU_DIVU);
        w_a_neg     = w_op_signed && i_op_a[WIDTH-1];
        w_b_neg     = w_op_signed && i_op_b[WIDTH-1];
        w_a_mag     = w_a_neg ? -i_op_a : i_op_a;
        w_b_mag     = w_b_neg ? -i_op_b : i_op_b;
    end

    // Shared WIDTH+1 adder: adds the multiplicand, or trial-subtracts the
    // divisor from the left-shifted remainder (bit WIDTH of the result = borrow).
    always_comb begin
        w_add_x = r_is_div ? {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]}
                           : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        w_add_y = {1'b0, r_b};
        w_sum   = r_is_div ? (w_add_x - w_add_y) : (w_add_x + w_add_y);
        if (r_is_div) begin
            w_acc_step = w_sum[WIDTH] ? {w_add_x[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                  : {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_q_mag  = r_acc[WIDTH-1:0];
        w_r_mag  = r_acc[2*WIDTH-1:WIDTH];
        w_quo    = r_neg_q ? -w_q_mag : w_q_mag;
        w_rem    = r_neg_r ? -w_r_mag : w_r_mag;
        w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = r_is_div ? (r_dbz_op ? '1 : w_quo) : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz_op <= 1'b0;
        end else if (w_load) begin
            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
            r_b      <= w_b_mag;
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= w_op_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dbz_op <= w_op_div && (i_op_b == '0);
        end else if (w_step) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_hi  <= w_res_hi;
                r_lo  <= w_res_lo;
                r_dbz <= r_dbz_op;
            end else if (w_wr_ok) begin
                if (i_hi_we) r_hi <= i_wdata;
                if (i_lo_we) r_lo <= i_wdata;
            end
        end
    end

    assign o_busy        = w_busy;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO from a reference model are
// queued at issue and compared when done pulses.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           t_issue;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    sb_t          sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           busy_run = 0;
    logic         prev_done = 1'b0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dbz = 1'b0;

    mul_div_unit #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_op          (op),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
        .i_flush       (flush),
        .i_hi_we       (hi_we),
        .i_lo_we       (lo_we),
        .i_wdata       (wdata),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz),
        .o_hi          (hi),
        .o_lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic sb_t model(input logic [1:0] m_op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
        sb_t                r;
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic [63:0]        p;
        int signed          qi;
        int signed          ri;
        r.dbz = 1'b0;
        r.t_issue = 0;
        sa  = $signed(a);
        sbv = $signed(b);
        case (m_op)
            MDU_MULT:  p = sa * sbv;
            MDU_MULTU: p = {32'd0, a} * {32'd0, b};
            default:   p = '0;
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        if (m_op == MDU_DIV || m_op == MDU_DIVU) begin
            if (b == '0) begin
                r.lo  = '1;
                r.hi  = a;
                r.dbz = 1'b1;
            end else if (m_op == MDU_DIVU) begin
                r.lo = a / b;
                r.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r.lo = 32'h8000_0000;
                r.hi = '0;
            end else begin
                qi = $signed(a) / $signed(b);
                ri = $signed(a) % $signed(b);
                r.lo = qi;
                r.hi = ri;
            end
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b);
        sb_t e;
        e = model(m_op, a, b);
        e.t_issue = cyc + 1;
        op = m_op;
        op_a = a;
        op_b = b;
        start = 1'b1;
        if (!busy && !flush) sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) check_eq("done_timeout", done, 1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            check_eq("done_width", prev_done, 0);
            check_eq("busy_cycles", busy_run, W + 1);
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                check_eq("hi", hi, e.hi);
                check_eq("lo", lo, e.lo);
                check_eq("div_by_zero", dbz, e.dbz);
                check_eq("latency", cyc - e.t_issue, W + 1);
                exp_hi  = e.hi;
                exp_lo  = e.lo;
                exp_dbz = e.dbz;
            end
        end
        prev_done = done;
        busy_run = busy ? busy_run + 1 : 0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_dbz", dbz, 0);
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);

        // Signed multiply with a start pulse mid-flight that must be ignored.
        issue(MDU_MULT, 32'd7, 32'hFFFF_FFFD);
        repeat (4) @(negedge clk);
        op = MDU_MULTU;
        op_a = 32'd5;
        op_b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Back-to-back issue in the done cycle.
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        issue(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        issue(MDU_DIVU, 32'h0000_0064, 32'd0);
        wait_done();
        issue(MDU_MULTU, 32'd2, 32'd3);
        wait_done();
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done();

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
            issue(2'($urandom_range(0, 3)), ra, rb);
            wait_done();
        end

        // Direct write together with start: write lands, completion overwrites.
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h1357_9BDF;
        issue(MDU_MULTU, 32'd9, 32'd11);
        hi_we = 1'b0;
        check_eq("hi_we_with_start", hi, 32'h1357_9BDF);
        wait_done();

        // Flush: preload LO, abort mid-run, LO/HI/div_by_zero untouched.
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'hAAAA_5555;
        @(negedge clk);
        lo_we = 1'b0;
        exp_lo = 32'hAAAA_5555;
        check_eq("lo_preload", lo, 32'hAAAA_5555);
        issue(MDU_MULT, 32'h0000_1234, 32'h0000_5678);
        repeat (4) @(negedge clk);
        op = MDU_DIVU;
        op_a = 32'd77;
        op_b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        lo_we = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", busy, 0);
        check_eq("flush_done", done, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        repeat (40) @(negedge clk);
        check_eq("flush_lo", lo, exp_lo);
        check_eq("flush_hi", hi, exp_hi);
        check_eq("flush_dbz", dbz, exp_dbz);

        // Flush alongside start in IDLE drops the start.
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_eq("flush_start_dropped", busy, 0);

        // Reset mid-divide, then immediate restart.
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (sb.size() != 0) void'(sb.pop_back());
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_hi", hi, 0);
        check_eq("midrst_lo", lo, 0);
        check_eq("midrst_dbz", dbz, 0);
        exp_hi = '0;
        exp_lo = '0;
        exp_dbz = 1'b0;
        rst = 1'b0;
        issue(MDU_DIVU, 32'd1000, 32'd7);
        wait_done();

        @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
